// File: rtl/mod_addsub_pipe.sv
// Two-stage pipelined modular add/subtract with a valid/ready handshake.
// S1 forms the raw sum/difference, S2 applies the single modulus correction.
module mod_addsub_pipe #(
  parameter int unsigned WIDTH = 255,
  parameter int unsigned TAG_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_q,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_data,
  output logic [TAG_W-1:0] o_out_tag,
  output logic             o_busy
);

  localparam int unsigned SW = WIDTH + 1;

  logic             v1, v2;
  logic [WIDTH-1:0] raw1, q1;
  logic             flag1, sub1;
  logic [TAG_W-1:0] tag1;
  logic [WIDTH-1:0] r2;
  logic [TAG_W-1:0] tag2;

  logic             en;
  logic [SW-1:0]    s1_sum;
  logic             s1_flag;
  logic [SW-1:0]    s2_t;
  logic [WIDTH-1:0] s2_r;

  // Whole pipe advances together; a bubble in S2 never blocks the input.
  assign en = !v2 || i_out_ready;

  // S1: raw sum, or A + ~B + 1 for subtract; flag is carry (add) or borrow (sub).
  always_comb begin
    s1_sum  = '0;
    s1_flag = 1'b0;
    if (i_sub) begin
      s1_sum  = {1'b0, i_a} + {1'b0, ~i_b} + SW'(1);
      s1_flag = ~s1_sum[WIDTH];
    end else begin
      s1_sum  = {1'b0, i_a} + {1'b0, i_b};
      s1_flag = s1_sum[WIDTH];
    end
  end

  // S2: add subtracts Q when the true sum reaches Q; sub adds Q back on borrow.
  always_comb begin
    s2_t = {1'b0, raw1} - {1'b0, q1};
    s2_r = raw1;
    if (sub1) begin
      if (flag1) s2_r = raw1 + q1;
    end else begin
      if (flag1 || !s2_t[WIDTH]) s2_r = s2_t[WIDTH-1:0];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      raw1  <= '0;
      q1    <= '0;
      flag1 <= 1'b0;
      sub1  <= 1'b0;
      tag1  <= '0;
      r2    <= '0;
      tag2  <= '0;
    end else if (en) begin
      v1    <= i_in_valid;
      v2    <= v1;
      raw1  <= s1_sum[WIDTH-1:0];
      q1    <= i_q;
      flag1 <= s1_flag;
      sub1  <= i_sub;
      tag1  <= i_tag;
      r2    <= s2_r;
      tag2  <= tag1;
    end
  end

  assign o_in_ready  = en;
  assign o_out_valid = v2;
  assign o_out_data  = r2;
  assign o_out_tag   = tag2;
  assign o_busy      = v1 | v2;

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Self-checking bench for mod_addsub_pipe: 8-bit instance for directed, random,
// stall and reset sequences; 255-bit instance for the wide-modulus corner cases.
module tb_mod_addsub_pipe;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // 8-bit instance
  logic       in_valid, in_ready, sub, out_valid, out_ready, busy;
  logic [7:0] a, b, q, out_data;
  logic [3:0] tag, out_tag;

  mod_addsub_pipe #(.WIDTH(8), .TAG_W(4)) dut8 (
    .i_clk(clk), .i_rst(rst),
    .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_sub(sub), .i_a(a), .i_b(b), .i_q(q), .i_tag(tag),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_data(out_data), .o_out_tag(out_tag), .o_busy(busy)
  );

  // 255-bit instance
  logic         w_in_valid, w_in_ready, w_sub, w_out_valid, w_busy;
  logic [254:0] w_a, w_b, w_q, w_out_data;
  logic [3:0]   w_tag, w_out_tag;

  mod_addsub_pipe #(.WIDTH(255), .TAG_W(4)) dut255 (
    .i_clk(clk), .i_rst(rst),
    .i_in_valid(w_in_valid), .o_in_ready(w_in_ready),
    .i_sub(w_sub), .i_a(w_a), .i_b(w_b), .i_q(w_q), .i_tag(w_tag),
    .o_out_valid(w_out_valid), .i_out_ready(1'b1),
    .o_out_data(w_out_data), .o_out_tag(w_out_tag), .o_busy(w_busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_pop   = 0;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] tag;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic       sub;
    logic [7:0] a, b, q, r;
  } vec_t;

  task automatic check(input string name, input logic [254:0] act, input logic [254:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference: plain modular arithmetic on in-range operands.
  function automatic logic [7:0] model(input logic s, input int ai, input int bi, input int qi);
    if (s) return 8'((ai - bi + qi) % qi);
    else   return 8'((ai + bi) % qi);
  endfunction

  // One clock cycle on the 8-bit DUT; outputs scored at negedge+1.
  task automatic cycle(input logic v, input logic s, input logic [7:0] ai, input logic [7:0] bi,
                       input logic [7:0] qi, input logic [3:0] ti, input logic ordy,
                       input logic [7:0] e);
    exp_t x;
    @(negedge clk);
    in_valid = v; sub = s; a = ai; b = bi; q = qi; tag = ti; out_ready = ordy;
    #1;
    if (out_valid && ordy) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 255'(1), 255'(0));
      end else begin
        x = exp_q.pop_front();
        n_pop++;
        check("out_data", 255'(out_data), 255'(x.data));
        check("out_tag", 255'(out_tag), 255'(x.tag));
      end
    end
    if (v && in_ready) exp_q.push_back({e, ti});
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 1'b0, 8'd0, 8'd0, 8'd1, 4'd0, ordy, 8'd0);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) idle(1'b1);
    check(name, 255'(exp_q.size()), 255'(0));
    exp_q.delete();
  endtask

  initial begin
    vec_t         vt[6];
    logic [7:0]   hold_d;
    logic [3:0]   hold_t;
    logic [254:0] wq, wexp[3];
    logic [254:0] wa[3], wb[3];
    logic         ws[3];
    int           qi, ai, bi;
    logic         si;

    vt[0] = '{1'b0, 8'd200, 8'd100, 8'd251, 8'd49};
    vt[1] = '{1'b0, 8'd125, 8'd126, 8'd251, 8'd0};
    vt[2] = '{1'b0, 8'd250, 8'd0,   8'd251, 8'd250};
    vt[3] = '{1'b1, 8'd10,  8'd20,  8'd251, 8'd241};
    vt[4] = '{1'b1, 8'd20,  8'd10,  8'd251, 8'd10};
    vt[5] = '{1'b1, 8'd77,  8'd77,  8'd251, 8'd0};

    in_valid = 0; sub = 0; a = 0; b = 0; q = 1; tag = 0; out_ready = 1;
    w_in_valid = 0; w_sub = 0; w_a = '0; w_b = '0; w_q = '0; w_tag = '0;

    rst = 1'b1;
    #12;
    check("rst_out_valid", 255'(out_valid), 255'(0));
    check("rst_out_data", 255'(out_data), 255'(0));
    check("rst_out_tag", 255'(out_tag), 255'(0));
    check("rst_busy", 255'(busy), 255'(0));
    check("rst_in_ready", 255'(in_ready), 255'(1));
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors, one per cycle
    for (int i = 0; i < 6; i++)
      cycle(1'b1, vt[i].sub, vt[i].a, vt[i].b, vt[i].q, 4'(i), 1'b1, vt[i].r);
    drain("directed_drain");

    // Random back-to-back stream, varying Q, tags 0..15
    n_pop = 0;
    for (int i = 0; i < 16; i++) begin
      qi = int'($urandom_range(1, 255));
      ai = int'($urandom % 32'(qi));
      bi = int'($urandom % 32'(qi));
      si = 1'($urandom);
      cycle(1'b1, si, 8'(ai), 8'(bi), 8'(qi), 4'(i), 1'b1, model(si, ai, bi, qi));
      check("stream_in_ready", 255'(in_ready), 255'(1));
      if (i >= 2) check("stream_out_valid", 255'(out_valid), 255'(1));
    end
    drain("stream_drain");
    check("stream_count", 255'(n_pop), 255'(16));

    // Stall with two results in flight
    n_pop = 0;
    cycle(1'b1, 1'b0, 8'd5, 8'd9, 8'd11, 4'd1, 1'b1, 8'd3);
    cycle(1'b1, 1'b1, 8'd2, 8'd7, 8'd13, 4'd2, 1'b1, 8'd8);
    hold_d = 8'd0; hold_t = 4'd0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 8'd90, 8'd80, 8'd97, 4'd3, 1'b0, 8'd73);
      check("stall_in_ready", 255'(in_ready), 255'(0));
      check("stall_out_valid", 255'(out_valid), 255'(1));
      if (i == 0) begin
        hold_d = out_data;
        hold_t = out_tag;
        check("stall_head_data", 255'(out_data), 255'(3));
      end else begin
        check("stall_data_hold", 255'(out_data), 255'(hold_d));
        check("stall_tag_hold", 255'(out_tag), 255'(hold_t));
      end
    end
    cycle(1'b1, 1'b0, 8'd90, 8'd80, 8'd97, 4'd3, 1'b1, 8'd73);
    check("release_in_ready", 255'(in_ready), 255'(1));
    drain("stall_drain");
    check("stall_count", 255'(n_pop), 255'(3));

    // Reset with both stages full
    cycle(1'b1, 1'b0, 8'd1, 8'd2, 8'd7, 4'd4, 1'b1, 8'd3);
    cycle(1'b1, 1'b0, 8'd3, 8'd3, 8'd7, 4'd5, 1'b1, 8'd6);
    @(negedge clk);
    in_valid = 0;
    #1;
    check("pre_rst_busy", 255'(busy), 255'(1));
    check("pre_rst_out_valid", 255'(out_valid), 255'(1));
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", 255'(out_valid), 255'(0));
    check("async_rst_busy", 255'(busy), 255'(0));
    check("async_rst_out_data", 255'(out_data), 255'(0));
    check("async_rst_in_ready", 255'(in_ready), 255'(1));
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;

    // First post-reset transaction: valid appears only after the second edge
    cycle(1'b1, 1'b1, 8'd4, 8'd6, 8'd9, 4'd6, 1'b1, 8'd7);
    check("lat_edge0_valid", 255'(out_valid), 255'(0));
    idle(1'b1);
    check("lat_edge1_valid", 255'(out_valid), 255'(0));
    idle(1'b1);
    check("lat_edge2_valid", 255'(out_valid), 255'(1));
    drain("latency_drain");

    // 255-bit modulus 2^255-19
    wq = '1;
    wq = wq - 255'd18;
    ws[0] = 1'b0; wa[0] = wq - 255'd1; wb[0] = wq - 255'd1; wexp[0] = wq - 255'd2;
    ws[1] = 1'b1; wa[1] = '0;          wb[1] = 255'd1;      wexp[1] = wq - 255'd1;
    ws[2] = 1'b1; wa[2] = wq - 255'd1; wb[2] = '0;          wexp[2] = wq - 255'd1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k < 3) begin
        w_in_valid = 1'b1; w_sub = ws[k]; w_a = wa[k]; w_b = wb[k]; w_q = wq; w_tag = 4'(k + 8);
      end else begin
        w_in_valid = 1'b0;
      end
      #1;
      if (k >= 2) begin
        check("w255_valid", 255'(w_out_valid), 255'(1));
        check("w255_data", w_out_data, wexp[k-2]);
        check("w255_tag", 255'(w_out_tag), 255'(k + 6));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
